// File: rtl/digital_modulator_if.sv
// Bit-stream input and I/Q sample output bundle of the serial-bit baseband mapper.
// The master drives bits in and receives mapped samples; the slave is the mapper.
interface digital_modulator_if #(
  parameter int OUT_W = 8
);
  logic                    i_en;
  logic                    i_data_vld;
  logic                    i_data;
  logic [1:0]              i_mod;
  logic                    o_out_vld;
  logic signed [OUT_W-1:0] o_i;
  logic signed [OUT_W-1:0] o_q;

  modport master (
    output i_en, i_data_vld, i_data, i_mod,
    input  o_out_vld, o_i, o_q
  );

  modport slave (
    input  i_en, i_data_vld, i_data, i_mod,
    output o_out_vld, o_i, o_q
  );
endinterface

// File: rtl/digital_modulator.sv
// Serial-bit baseband mapper: gathers 1/2/4/6 bits MSB-first, maps them to a
// Gray-coded BPSK/QPSK/16QAM/64QAM point and emits one signed I/Q sample with a strobe.
module digital_modulator #(
  parameter int OUT_W = 8
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  digital_modulator_if.slave  bus
);

  localparam logic [1:0] MOD_BPSK  = 2'b00;
  localparam logic [1:0] MOD_QPSK  = 2'b01;
  localparam logic [1:0] MOD_QAM16 = 2'b10;
  localparam logic [1:0] MOD_QAM64 = 2'b11;

  if (OUT_W < 4) begin : g_bad_width
    $error("digital_modulator: OUT_W must be at least 4 to hold +/-7");
  end

  function automatic logic [2:0] bits_per_sym(input logic [1:0] mode);
    case (mode)
      MOD_BPSK:  return 3'd1;
      MOD_QPSK:  return 3'd2;
      MOD_QAM16: return 3'd4;
      default:   return 3'd6;
    endcase
  endfunction

  function automatic logic signed [OUT_W-1:0] sext(input logic signed [3:0] v);
    return OUT_W'(v);
  endfunction

  // A set bit selects the negative level.
  function automatic logic signed [3:0] lvl1(input logic b);
    return b ? -4'sd1 : 4'sd1;
  endfunction

  function automatic logic signed [3:0] lvl2(input logic [1:0] g);
    case (g)
      2'b00:   return -4'sd3;
      2'b01:   return -4'sd1;
      2'b11:   return 4'sd1;
      default: return 4'sd3;
    endcase
  endfunction

  function automatic logic signed [3:0] lvl3(input logic [2:0] g);
    case (g)
      3'b000:  return -4'sd7;
      3'b001:  return -4'sd5;
      3'b011:  return -4'sd3;
      3'b010:  return -4'sd1;
      3'b110:  return 4'sd1;
      3'b111:  return 4'sd3;
      3'b101:  return 4'sd5;
      default: return 4'sd7;
    endcase
  endfunction

  // The first received bit sits at position K-1 of the collected word.
  function automatic logic signed [OUT_W-1:0] map_i(input logic [1:0] mode,
                                                    input logic [5:0] sh);
    case (mode)
      MOD_BPSK:  return sext(lvl1(sh[0]));
      MOD_QPSK:  return sext(lvl1(sh[1]));
      MOD_QAM16: return sext(lvl2(sh[3:2]));
      default:   return sext(lvl3(sh[5:3]));
    endcase
  endfunction

  function automatic logic signed [OUT_W-1:0] map_q(input logic [1:0] mode,
                                                    input logic [5:0] sh);
    case (mode)
      MOD_BPSK:  return '0;
      MOD_QPSK:  return sext(lvl1(sh[0]));
      MOD_QAM16: return sext(lvl2(sh[1:0]));
      default:   return sext(lvl3(sh[2:0]));
    endcase
  endfunction

  logic [2:0]              cnt_p0;
  logic [5:0]              sh_p0;
  logic [1:0]              mode_p0;
  logic                    vld_p1;
  logic signed [OUT_W-1:0] i_p1;
  logic signed [OUT_W-1:0] q_p1;

  logic                    first_bit;
  logic [1:0]              mode_cur;
  logic [5:0]              sh_nxt;
  logic                    last_bit;

  // Stage p0: bit collection; the mode is taken live on a symbol's first bit.
  always_comb begin
    first_bit = (cnt_p0 == 3'd0);
    mode_cur  = first_bit ? bus.i_mod : mode_p0;
    sh_nxt    = first_bit ? {5'b0, bus.i_data} : {sh_p0[4:0], bus.i_data};
    last_bit  = ((cnt_p0 + 3'd1) == bits_per_sym(mode_cur));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_p0  <= '0;
      sh_p0   <= '0;
      mode_p0 <= MOD_BPSK;
      vld_p1  <= 1'b0;
      i_p1    <= '0;
      q_p1    <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (!bus.i_en) begin
        cnt_p0 <= '0;
        sh_p0  <= '0;
      end else if (bus.i_data_vld) begin
        if (first_bit) begin
          mode_p0 <= bus.i_mod;
        end
        // Stage p1: the last bit maps straight into the output registers.
        if (last_bit) begin
          cnt_p0 <= '0;
          sh_p0  <= '0;
          vld_p1 <= 1'b1;
          i_p1   <= map_i(mode_cur, sh_nxt);
          q_p1   <= map_q(mode_cur, sh_nxt);
        end else begin
          cnt_p0 <= cnt_p0 + 3'd1;
          sh_p0  <= sh_nxt;
        end
      end
    end
  end

  assign bus.o_out_vld = vld_p1;
  assign bus.o_i       = i_p1;
  assign bus.o_q       = q_p1;

endmodule

// File: tb/tb_digital_modulator.sv
// Directed bench for the serial-bit baseband mapper: vector table plus
// hand-written framing, pause, abort, mode-change and reset sequences.
module tb_digital_modulator;
  localparam int OUT_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  digital_modulator_if #(.OUT_W(OUT_W)) bus ();

  digital_modulator #(.OUT_W(OUT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0] mode;
    int         n;
    logic [5:0] bits;
    int         ei;
    int         eq;
  } vec_t;

  vec_t vecs[11];
  int   lvl3_tab[8] = '{-7, -5, -1, -3, 7, 5, 1, 3};
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int vld, input int ei, input int eq);
    chk({name, "_vld"}, int'(bus.o_out_vld), vld);
    chk({name, "_i"}, int'(bus.o_i), ei);
    chk({name, "_q"}, int'(bus.o_q), eq);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [1:0] mode, input int n, input logic [5:0] bits,
                          input int ei, input int eq, input string name);
    for (int j = n - 1; j >= 0; j--) begin
      bus.i_en       = 1'b1;
      bus.i_mod      = mode;
      bus.i_data_vld = 1'b1;
      bus.i_data     = bits[j];
      tick();
      if (j > 0) chk({name, "_early"}, int'(bus.o_out_vld), 0);
    end
    bus.i_data_vld = 1'b0;
    bus.i_data     = 1'b0;
    chk_out(name, 1, ei, eq);
    tick();
    chk_out({name, "_hold"}, 0, ei, eq);
  endtask

  initial begin
    logic [5:0] fb;
    int         strobes;
    int         ei;
    int         eq;

    vecs[0]  = '{2'b00, 1, 6'b000000,  1,  0};
    vecs[1]  = '{2'b00, 1, 6'b000001, -1,  0};
    vecs[2]  = '{2'b01, 2, 6'b000010, -1,  1};
    vecs[3]  = '{2'b01, 2, 6'b000001,  1, -1};
    vecs[4]  = '{2'b10, 4, 6'b000110, -1,  3};
    vecs[5]  = '{2'b10, 4, 6'b001100,  1, -3};
    vecs[6]  = '{2'b10, 4, 6'b001010,  3,  3};
    vecs[7]  = '{2'b11, 6, 6'b100000,  7, -7};
    vecs[8]  = '{2'b11, 6, 6'b011101, -3,  5};
    vecs[9]  = '{2'b11, 6, 6'b010110, -1,  1};
    vecs[10] = '{2'b11, 6, 6'b111001,  3, -5};

    bus.i_en = 1'b0; bus.i_data_vld = 1'b0; bus.i_data = 1'b0; bus.i_mod = 2'b00;

    // Reset held 40 ns, then 10 cycles with the block disabled.
    #2 rst_n = 1'b0;
    #20 chk_out("reset", 0, 0, 0);
    #20 rst_n = 1'b1;
    bus.i_mod = 2'b11;
    for (int c = 0; c < 10; c++) begin
      bus.i_data_vld = 1'b1;
      bus.i_data     = c[0];
      tick();
      chk_out("disabled", 0, 0, 0);
    end
    bus.i_data_vld = 1'b0;

    // BPSK: one valid bit per 8-cycle frame.
    bus.i_en = 1'b1; bus.i_mod = 2'b00;
    for (int f = 0; f < 2; f++) begin
      bus.i_data_vld = 1'b1;
      bus.i_data     = f[0];
      tick();
      bus.i_data_vld = 1'b0;
      chk_out("bpsk_frame", 1, f ? -1 : 1, 0);
      for (int c = 1; c < 8; c++) begin
        tick();
        chk_out("bpsk_idle", 0, f ? -1 : 1, 0);
      end
    end

    for (int v = 0; v < 11; v++)
      send_sym(vecs[v].mode, vecs[v].n, vecs[v].bits, vecs[v].ei, vecs[v].eq,
               $sformatf("vec%0d", v));

    // BPSK with a bit every cycle: a strobe every cycle.
    bus.i_mod = 2'b00; bus.i_data_vld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.i_data = ~c[0];
      tick();
      chk_out("bpsk_b2b", 1, c[0] ? 1 : -1, 0);
    end
    bus.i_data_vld = 1'b0;
    tick();
    chk_out("bpsk_b2b_end", 0, -1, 0);

    // 16QAM 0,1 then a 3-cycle data_vld gap then 1,1: collection pauses.
    bus.i_mod = 2'b10;
    bus.i_data_vld = 1'b1; bus.i_data = 1'b0; tick(); chk("pause_b0", int'(bus.o_out_vld), 0);
    bus.i_data = 1'b1; tick(); chk("pause_b1", int'(bus.o_out_vld), 0);
    bus.i_data_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("pause_gap", int'(bus.o_out_vld), 0);
    end
    send_sym(2'b10, 2, 6'b000011, -1, 1, "pause_tail");

    // 16QAM symbol with i_mod switched to BPSK after the first bit.
    bus.i_mod = 2'b10; bus.i_data_vld = 1'b1; bus.i_data = 1'b1;
    tick();
    chk("modechg_b0", int'(bus.o_out_vld), 0);
    send_sym(2'b00, 3, 6'b000011, 3, 1, "modechg");

    // 64QAM aborted after 3 bits by dropping i_en.
    bus.i_mod = 2'b11; bus.i_data_vld = 1'b1; bus.i_data = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_part", int'(bus.o_out_vld), 0);
    end
    bus.i_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk_out("abort_off", 0, 3, 1);
    end
    send_sym(2'b11, 6, 6'b000000, -7, -7, "abort_new");

    // Two 80-cycle 64QAM bursts (6 valid bits per 8 cycles) around a 20-cycle gap.
    for (int b = 0; b < 2; b++) begin
      strobes = 0;
      bus.i_en = 1'b1; bus.i_mod = 2'b11;
      for (int f = 0; f < 10; f++) begin
        fb = 6'((f + 10 * b) * 13 + 5);
        ei = lvl3_tab[fb[5:3]];
        eq = lvl3_tab[fb[2:0]];
        for (int c = 0; c < 8; c++) begin
          bus.i_data_vld = (c < 6);
          bus.i_data     = (c < 6) ? fb[5 - c] : 1'b0;
          tick();
          if (bus.o_out_vld) strobes++;
          chk("burst_vld", int'(bus.o_out_vld), (c == 5) ? 1 : 0);
          if (c == 5) begin
            chk("burst_i", int'(bus.o_i), ei);
            chk("burst_q", int'(bus.o_q), eq);
          end
        end
      end
      chk("burst_strobes", strobes, 10);
      bus.i_data_vld = 1'b0;
      if (b == 0) begin
        bus.i_en = 1'b0;
        for (int c = 0; c < 20; c++) begin
          bus.i_data_vld = 1'b1;
          bus.i_data     = c[1];
          tick();
          chk("burst_gap", int'(bus.o_out_vld), 0);
        end
      end
    end

    // Asynchronous reset in the middle of a 64QAM symbol.
    bus.i_en = 1'b1; bus.i_mod = 2'b11; bus.i_data_vld = 1'b1; bus.i_data = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 chk_out("midrst", 0, 0, 0);
    bus.i_data_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_out("midrst_after", 0, 0, 0);
    send_sym(2'b01, 2, 6'b000001, 1, -1, "midrst_new");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
